// File: rtl/conv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_arb_pkg
// Purpose  : Shared FSM state type and parameter derivations for the
//            conv engine round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package conv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // A valid-mode convolution yields X - F + 1 outputs.
  function automatic int calc_op_count(input int x_count, input int f_count);
    return x_count - f_count + 1;
  endfunction

  function automatic int calc_gnt_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int calc_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_engine_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker: first set request at or above
//            ptr, wrapping at N_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GNT_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GNT_W-1:0] ptr,
  output logic             found,
  output logic [GNT_W-1:0] idx
);

  logic [GNT_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = GNT_W'((int'(ptr) + k) % N_REQ);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_engine_arb.sv
`default_nettype none
// ============================================================================
// Module   : conv_engine_arb
// Purpose  : Round-robin scheduler sharing one 1-D conv engine among N_REQ
//            streams. Optional macro CONV_ENGINE_ARB_STATS_EN adds jobs_done.
// Revision : 1.0 - initial release
// ============================================================================
module conv_engine_arb
  import conv_arb_pkg::*;
#(
  parameter int T        = 16,
  parameter int N_REQ    = 4,
  parameter int X_COUNT  = 32,
  parameter int F_COUNT  = 6,
  parameter int OP_COUNT = calc_op_count(X_COUNT, F_COUNT),
  parameter int GNT_W    = calc_gnt_w(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ*T-1:0] req_data_in,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  output logic [T-1:0]       resp_data_out,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [T-1:0]       eng_data_out,
  output logic               eng_valid_out,
  input  logic               eng_ready_in,
  input  logic [T-1:0]       eng_data_in,
  input  logic               eng_valid_in,
  output logic               eng_ready_out,
  output logic [GNT_W-1:0]   gnt_id,
  output logic               busy
`ifdef CONV_ENGINE_ARB_STATS_EN
  ,
  output logic [15:0]        jobs_done
`endif
);

  localparam int c_IN_CNT_W  = calc_cnt_w(X_COUNT);
  localparam int c_OUT_CNT_W = calc_cnt_w(OP_COUNT);

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic [GNT_W-1:0]        r_gnt_id;
  logic [GNT_W-1:0]        r_rr_ptr;
  logic [GNT_W-1:0]        w_pick_idx;
  logic [GNT_W-1:0]        w_rr_next;
  logic                    w_pick_found;
  logic [c_IN_CNT_W-1:0]   r_in_cnt;
  logic [c_OUT_CNT_W-1:0]  r_out_cnt;
  logic                    w_in_beat;
  logic                    w_out_beat;
  logic                    w_in_last;
  logic                    w_out_last;
  logic [T-1:0]            w_req_data [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_data[gi] = req_data_in[gi*T +: T];
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ),
    .GNT_W (GNT_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  assign w_in_beat  = (r_state == LOAD)  && eng_valid_out && eng_ready_in;
  assign w_out_beat = (r_state == DRAIN) && eng_valid_in  && eng_ready_out;
  assign w_in_last  = w_in_beat  && (r_in_cnt  == c_IN_CNT_W'(X_COUNT - 1));
  assign w_out_last = w_out_beat && (r_out_cnt == c_OUT_CNT_W'(OP_COUNT - 1));
  assign w_rr_next  = (r_gnt_id == GNT_W'(N_REQ - 1)) ? '0 : r_gnt_id + GNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_pick_found) w_next_state = LOAD;
      LOAD:    if (w_in_last)    w_next_state = DRAIN;
      DRAIN:   if (w_out_last)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Pure pass-through muxes; nothing is buffered between requester and engine.
  always_comb begin
    req_ready     = '0;
    eng_valid_out = 1'b0;
    eng_data_out  = '0;
    resp_valid    = '0;
    resp_data_out = '0;
    eng_ready_out = 1'b0;
    if (r_state == LOAD) begin
      eng_data_out        = w_req_data[r_gnt_id];
      eng_valid_out       = req_valid[r_gnt_id];
      req_ready[r_gnt_id] = eng_ready_in;
    end
    if (r_state == DRAIN) begin
      resp_data_out        = eng_data_in;
      resp_valid[r_gnt_id] = eng_valid_in;
      eng_ready_out        = resp_ready[r_gnt_id];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_id  <= '0;
      r_rr_ptr  <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && w_pick_found) begin
        r_gnt_id <= w_pick_idx;
      end
      if (w_in_beat) begin
        r_in_cnt <= w_in_last ? '0 : r_in_cnt + c_IN_CNT_W'(1);
      end
      if (w_out_beat) begin
        r_out_cnt <= w_out_last ? '0 : r_out_cnt + c_OUT_CNT_W'(1);
      end
      if (w_out_last) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign gnt_id = r_gnt_id;
  assign busy   = (r_state != IDLE);

`ifdef CONV_ENGINE_ARB_STATS_EN
  logic [15:0] r_jobs_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_jobs_done <= '0;
    end else if (w_out_last && (r_jobs_done != 16'hFFFF)) begin
      r_jobs_done <= r_jobs_done + 16'd1;
    end
  end

  assign jobs_done = r_jobs_done;
`else
  // Job statistics are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_engine_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_engine_arb
// Purpose  : Scoreboard bench for conv_engine_arb with a behavioural engine
//            and requester models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_engine_arb;

  localparam int T  = 16;
  localparam int N  = 4;
  localparam int X  = 32;
  localparam int OP = 27;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*T-1:0] req_data_in;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [T-1:0]   resp_data_out;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [T-1:0]   eng_data_out;
  logic           eng_valid_out;
  logic           eng_ready_in;
  logic [T-1:0]   eng_data_in;
  logic           eng_valid_in;
  logic           eng_ready_out;
  logic [1:0]     gnt_id;
  logic           busy;
`ifdef CONV_ENGINE_ARB_STATS_EN
  logic [15:0]    jobs_done;
`endif

  conv_engine_arb u_dut (
    .clk           (clk),
    .reset         (reset),
    .req_data_in   (req_data_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .resp_data_out (resp_data_out),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .eng_data_out  (eng_data_out),
    .eng_valid_out (eng_valid_out),
    .eng_ready_in  (eng_ready_in),
    .eng_data_in   (eng_data_in),
    .eng_valid_in  (eng_valid_in),
    .eng_ready_out (eng_ready_out),
    .gnt_id        (gnt_id),
`ifdef CONV_ENGINE_ARB_STATS_EN
    .jobs_done     (jobs_done),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic logic [15:0] word(input int g, input int k);
    return {4'(g), 4'h0, 8'(k)};
  endfunction

  // Scoreboard queues
  int          gq[$];
  logic [15:0] qin[$];
  logic [15:0] qout[$];

  task automatic push_job(input int g);
    gq.push_back(g);
    for (int k = 1; k <= X; k++)  qin.push_back(word(g, k));
    for (int k = 1; k <= OP; k++) qout.push_back(word(g, k) ^ 16'h8000);
  endtask

  // Requester / engine model state
  int          words_sent [N];
  int          jobs_left  [N];
  int          stall_at   [N];
  int          stall_left [N];
  bit          bp_mode   = 1'b0;
  bit          junk_mode = 1'b0;
  logic [15:0] e_buf [X];
  int          e_cnt  = 0;
  int          e_idx  = 0;
  bit          e_prod = 1'b0;

  logic [N-1:0] f_req;
  logic         f_ein;
  logic         f_eout;
  logic [T-1:0] f_edata;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (jobs_left[i] > 0 && words_sent[i] == stall_at[i] && stall_left[i] > 0) begin
        req_valid[i] = 1'b0;
        stall_left[i]--;
      end else begin
        req_valid[i] = (jobs_left[i] > 0);
      end
      req_data_in[i*T +: T] = word(i, words_sent[i] + 1);
      resp_ready[i] = (bp_mode && e_prod) ? ~resp_ready[i] : 1'b1;
    end
    eng_ready_in = 1'b1;
    eng_valid_in = e_prod | junk_mode;
    eng_data_in  = e_prod ? (e_buf[e_idx] ^ 16'h8000) : 16'hDEAD;
  endtask

  initial begin : drv
    for (int i = 0; i < N; i++) begin
      words_sent[i] = 0; jobs_left[i] = 0; stall_at[i] = -1; stall_left[i] = 0;
    end
    req_valid  = '0;
    resp_ready = '1;
    drive();
    forever begin
      @(negedge clk);
      f_req   = req_valid & req_ready;
      f_ein   = eng_valid_out & eng_ready_in;
      f_edata = eng_data_out;
      f_eout  = eng_valid_in & eng_ready_out;
      @(posedge clk);
      #1;
      if (reset) begin
        for (int i = 0; i < N; i++) words_sent[i] = 0;
        e_cnt = 0; e_idx = 0; e_prod = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (f_req[i]) begin
            words_sent[i]++;
            if (words_sent[i] == X) begin
              words_sent[i] = 0;
              if (jobs_left[i] > 0) jobs_left[i]--;
            end
          end
        end
        if (f_ein) begin
          e_buf[e_cnt] = f_edata;
          e_cnt++;
          if (e_cnt == X) begin e_cnt = 0; e_prod = 1'b1; e_idx = 0; end
        end
        if (f_eout) begin
          e_idx++;
          if (e_idx == OP) begin e_idx = 0; e_prod = 1'b0; end
        end
      end
      drive();
    end
  end

  // Monitor: tracks expected phase and pops the scoreboard on DUT beats
  int          m_phase  = 0;
  int          m_in     = 0;
  int          m_out    = 0;
  int          cur_gnt  = 0;
  int          gap_cnt  = 0;
  int          load_cyc = 0;
  int          tot_in   = 0;
  int          tot_out  = 0;
  bit          gap_check = 1'b0;
  bit          first_job = 1'b1;
  int          ph;
  logic [N-1:0] exp_rr;
  logic [N-1:0] exp_rv;

  initial begin : mon
    forever begin
      @(negedge clk);
      if (reset) begin
        m_phase = 0; m_in = 0; m_out = 0; gap_cnt = 0; first_job = 1'b1;
      end else begin
        if (m_phase == 0) begin
          if (busy) begin
            if (gq.size() == 0) fail_now("grant_unexpected", $sformatf("busy=1 gnt_id=%0d with no grant expected", gnt_id));
            else begin
              cur_gnt = gq.pop_front();
              chk("grant", int'(gnt_id), cur_gnt);
            end
            if (gap_check && !first_job) chk("idle_gap", gap_cnt, 1);
            first_job = 1'b0; gap_cnt = 0; m_phase = 1; load_cyc = 0;
          end else begin
            gap_cnt++;
          end
        end else begin
          chk("busy_hold", int'(busy), 1);
          chk("gnt_hold", int'(gnt_id), cur_gnt);
        end
        if (m_phase == 1) load_cyc++;

        exp_rr = '0;
        if (m_phase == 1) exp_rr[cur_gnt] = eng_ready_in;
        chk("req_ready", int'(req_ready), int'(exp_rr));
        chk("eng_valid_out", int'(eng_valid_out), (m_phase == 1) ? int'(req_valid[cur_gnt]) : 0);
        chk("eng_ready_out", int'(eng_ready_out), (m_phase == 2) ? int'(resp_ready[cur_gnt]) : 0);
        exp_rv = '0;
        if (m_phase == 2) exp_rv[cur_gnt] = eng_valid_in;
        chk("resp_valid", int'(resp_valid), int'(exp_rv));
        chk("resp_data_out", int'(resp_data_out), (m_phase == 2) ? int'(eng_data_in) : 0);

        ph = m_phase;
        if (eng_valid_out && eng_ready_in) begin
          if (qin.size() == 0) fail_now("eng_in_unexpected", $sformatf("beat data 0x%0h", eng_data_out));
          else chk("eng_in_data", int'(eng_data_out), int'(qin.pop_front()));
          tot_in++; m_in++;
          if (m_in == X) begin m_in = 0; m_phase = 2; end
        end
        if (ph == 2 && resp_valid[cur_gnt] && resp_ready[cur_gnt]) begin
          if (qout.size() == 0) fail_now("resp_unexpected", $sformatf("result 0x%0h", resp_data_out));
          else chk("resp_data", int'(resp_data_out), int'(qout.pop_front()));
          tot_out++; m_out++;
          if (m_out == OP) begin m_out = 0; m_phase = 0; end
        end
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (!(gq.size() == 0 && qin.size() == 0 && qout.size() == 0 && m_phase == 0 && !busy)) begin
      @(negedge clk);
      c++;
      if (c > budget) begin
        fail_now({name, "_timeout"}, $sformatf("job not finished in %0d cycles", budget));
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},     int'(req_ready),     0);
    chk({tag, "_resp_valid"},    int'(resp_valid),    0);
    chk({tag, "_eng_valid_out"}, int'(eng_valid_out), 0);
    chk({tag, "_eng_ready_out"}, int'(eng_ready_out), 0);
    chk({tag, "_resp_data"},     int'(resp_data_out), 0);
    chk({tag, "_gnt_id"},        int'(gnt_id),        0);
    chk({tag, "_busy"},          int'(busy),          0);
  endtask

  task automatic flush_model();
    gq.delete(); qin.delete(); qout.delete();
    for (int i = 0; i < N; i++) jobs_left[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    flush_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int base_in, base_out, c;

  initial begin : test
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single requester 2
    base_in = tot_in; base_out = tot_out;
    push_job(2);
    jobs_left[2] = 1;
    @(negedge clk);
    chk("arb_cycle_busy", int'(busy), 0);
    @(negedge clk);
    chk("gnt_latency_busy", int'(busy), 1);
    chk("gnt_latency_id", int'(gnt_id), 2);
    wait_done("single", 400);
    chk("single_in_beats", tot_in - base_in, X);
    chk("single_out_beats", tot_out - base_out, OP);
    chk("single_load_cycles", load_cyc, X);

    // All four requesting from reset: order 0,1,2,3,0
    do_reset();
    base_in = tot_in; base_out = tot_out;
    gap_check = 1'b1;
    push_job(0); push_job(1); push_job(2); push_job(3); push_job(0);
    jobs_left[0] = 2; jobs_left[1] = 1; jobs_left[2] = 1; jobs_left[3] = 1;
    wait_done("rr", 1500);
    gap_check = 1'b0;
    chk("rr_in_beats", tot_in - base_in, 5 * X);
    chk("rr_out_beats", tot_out - base_out, 5 * OP);
`ifdef CONV_ENGINE_ARB_STATS_EN
    chk("stats_five_jobs", int'(jobs_done), 5);
`endif
    do_reset();
`ifdef CONV_ENGINE_ARB_STATS_EN
    chk("stats_after_reset", int'(jobs_done), 0);
`endif

    // Result backpressure on requester 1
    base_out = tot_out;
    bp_mode = 1'b1;
    push_job(1);
    jobs_left[1] = 1;
    wait_done("bp", 600);
    bp_mode = 1'b0;
    chk("bp_out_beats", tot_out - base_out, OP);

    // Input stall on requester 3 after word 15, with stray engine results in LOAD
    junk_mode = 1'b1;
    stall_at[3] = 15; stall_left[3] = 10;
    push_job(3);
    jobs_left[3] = 1;
    wait_done("stall", 600);
    junk_mode = 1'b0;
    stall_at[3] = -1;
    chk("stall_load_cycles", load_cyc, X + 10);

    // Reset at LOAD beat 20 of requester 1, then a fresh job from requester 3
    base_in = tot_in;
    push_job(1);
    jobs_left[1] = 1;
    c = 0;
    while (tot_in - base_in < 20 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("midjob_beats_reached", int'(tot_in - base_in >= 20), 1);
    chk("midjob_gnt", int'(gnt_id), 1);
    reset = 1'b1;
    jobs_left[1] = 0;
    @(negedge clk);
    chk_reset_vals("midjob");
    flush_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    base_in = tot_in; base_out = tot_out;
    push_job(3);
    jobs_left[3] = 1;
    wait_done("post_reset", 400);
    chk("post_reset_in_beats", tot_in - base_in, X);
    chk("post_reset_out_beats", tot_out - base_out, OP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
